// File: rtl/video_timing_pkg.sv
// Shared BT.656 timing constants, FSM state encoding and the pixel-pair payload.
package video_timing_pkg;

  localparam int unsigned WORD_W            = 10;
  localparam int unsigned PAIR_W            = 9;
  localparam int unsigned ACTIVE_PAIRS_NTSC = 360;

  localparam logic [WORD_W-1:0] PREAMBLE_WORD = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } avx_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] cb;
    logic [WORD_W-1:0] y0;
    logic [WORD_W-1:0] cr;
    logic [WORD_W-1:0] y1;
  } ycbcr_pair_t;

endpackage

// File: rtl/ycbcr_pair_packer.sv
// Demultiplexes Cb/Y0/Cr/Y1 words into one registered pixel-pair with a strobe.
module ycbcr_pair_packer
  import video_timing_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              phase_clr,
  input  logic [WORD_W-1:0] word,
  output logic [1:0]        phase,
  output logic              pair_done_c,
  output logic              pix_valid,
  output ycbcr_pair_t       pair
);

  logic [WORD_W-1:0] cb_q;
  logic [WORD_W-1:0] y0_q;
  logic [WORD_W-1:0] cr_q;

  // The Y1 word completes a group on this edge; a phase clear always restarts at Cb.
  assign pair_done_c = capture_en && !phase_clr && (phase == 2'd3);

  // Phase counter, component holding registers and output pair register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= 2'd0;
      cb_q      <= '0;
      y0_q      <= '0;
      cr_q      <= '0;
      pair      <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      if (capture_en) begin
        if (phase_clr) begin
          cb_q  <= word;
          phase <= 2'd1;
        end else begin
          unique case (phase)
            2'd0: cb_q <= word;
            2'd1: y0_q <= word;
            2'd2: cr_q <= word;
            2'd3: begin
              pair      <= '{cb: cb_q, y0: y0_q, cr: cr_q, y1: word};
              pix_valid <= 1'b1;
            end
          endcase
          phase <= phase + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/active_video_extractor.sv
// Extracts active-video 4:2:2 groups from a BT.656 stream and tags them with position/field.
module active_video_extractor
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_PAIRS = ACTIVE_PAIRS_NTSC,
  parameter int unsigned LINE_W       = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] bt_656,
  input  logic              H,
  input  logic              V,
  input  logic              F,
  output logic              pix_valid,
  output logic [WORD_W-1:0] pix_cb,
  output logic [WORD_W-1:0] pix_y0,
  output logic [WORD_W-1:0] pix_cr,
  output logic [WORD_W-1:0] pix_y1,
  output logic [PAIR_W-1:0] pix_x,
  output logic [LINE_W-1:0] line_y,
  output logic              field,
  output logic              sol,
  output logic              sof,
  output logic              line_err
);

  avx_state_e        state;
  logic              h_prev;
  logic              v_prev;
  logic              armed;
  logic [PAIR_W-1:0] pair_cnt;
  logic [1:0]        phase;
  logic              pair_done_c;
  ycbcr_pair_t       pair;

  logic line_start_c;
  logic h_end_c;
  logic pre_end_c;
  logic eol_c;
  logic capture_c;
  logic v_rise_c;
  logic pre_err_c;

  // h_prev resets high, so a start also needs one real blanking sample since reset;
  // otherwise a reset released mid-line would look like an H falling edge.
  assign line_start_c = (state == IDLE) && armed && h_prev && !H && !V;
  assign h_end_c      = (state == ACTIVE) && H;
  assign pre_end_c    = (state == ACTIVE) && !H && (bt_656 == PREAMBLE_WORD);
  assign eol_c        = h_end_c || pre_end_c;
  assign capture_c    = line_start_c || ((state == ACTIVE) && !eol_c);
  assign v_rise_c     = V && !v_prev;
  assign pre_err_c    = (phase != 2'd0) || (pair_cnt != PAIR_W'(ACTIVE_PAIRS));

  ycbcr_pair_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .capture_en  (capture_c),
    .phase_clr   (line_start_c),
    .word        (bt_656),
    .phase       (phase),
    .pair_done_c (pair_done_c),
    .pix_valid   (pix_valid),
    .pair        (pair)
  );

  assign pix_cb = pair.cb;
  assign pix_y0 = pair.y0;
  assign pix_cr = pair.cr;
  assign pix_y1 = pair.y1;

  // Line FSM, sync edge history, pair counter and end-of-line error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      h_prev   <= 1'b1;
      v_prev   <= 1'b0;
      armed    <= 1'b0;
      field    <= 1'b0;
      pair_cnt <= '0;
      line_err <= 1'b0;
    end else begin
      h_prev   <= H;
      v_prev   <= V;
      line_err <= 1'b0;
      if (H) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (line_start_c) begin
            state    <= ACTIVE;
            field    <= F;
            pair_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (h_end_c) begin
            state    <= IDLE;
            line_err <= 1'b1;
          end else if (pre_end_c) begin
            state    <= DRAIN;
            line_err <= pre_err_c;
          end else if (pair_done_c && (pair_cnt != '1)) begin
            pair_cnt <= pair_cnt + PAIR_W'(1);
          end
        end
        DRAIN: begin
          if (H) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Position tags captured alongside each completed pair; held until the next strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_x <= '0;
      sol   <= 1'b0;
      sof   <= 1'b0;
    end else if (pair_done_c) begin
      pix_x <= pair_cnt;
      sol   <= (pair_cnt == '0);
      sof   <= (pair_cnt == '0) && (line_y == '0);
    end
  end

  // Active-line counter: cleared by V rising (wins over end of line), saturating increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_y <= '0;
    end else if (v_rise_c) begin
      line_y <= '0;
    end else if (eol_c && (line_y != '1)) begin
      line_y <= line_y + LINE_W'(1);
    end
  end

endmodule

// File: tb/tb_active_video_extractor.sv
// Randomized bench for active_video_extractor with a line-level reference model.
module tb_active_video_extractor;

  typedef struct packed {
    logic [9:0]  cb;
    logic [9:0]  y0;
    logic [9:0]  cr;
    logic [9:0]  y1;
    logic [8:0]  x;
    logic [8:0]  ly;
    logic        fld;
    logic        sol;
    logic        sof;
    logic [31:0] cyc;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] bt_656;
  logic       H, V, F;
  logic       pix_valid;
  logic [9:0] pix_cb, pix_y0, pix_cr, pix_y1;
  logic [8:0] pix_x;
  logic [8:0] line_y;
  logic       field, sol, sof, line_err;

  int   ncyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   m_line_y = 0;
  logic [9:0] g_cb, g_y0, g_cr;
  rec_t obs_q[$];
  rec_t exp_q[$];
  int   err_q[$];
  int   exp_err_q[$];
  rec_t mon_r;

  active_video_extractor #(.ACTIVE_PAIRS(360), .LINE_W(9)) dut (
    .clk(clk), .reset(reset), .bt_656(bt_656), .H(H), .V(V), .F(F),
    .pix_valid(pix_valid), .pix_cb(pix_cb), .pix_y0(pix_y0), .pix_cr(pix_cr),
    .pix_y1(pix_y1), .pix_x(pix_x), .line_y(line_y), .field(field),
    .sol(sol), .sof(sof), .line_err(line_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= ncyc + 1;

  // Observe strobes and error pulses half a cycle after the active edge.
  always @(negedge clk) begin
    if (pix_valid) begin
      mon_r = {pix_cb, pix_y0, pix_cr, pix_y1, pix_x, line_y, field, sol, sof, 32'(ncyc)};
      obs_q.push_back(mon_r);
    end
    if (line_err) err_q.push_back(ncyc);
  end

  task automatic drive(input logic [9:0] w, input logic h, input logic v, input logic f);
    bt_656 = w; H = h; V = v; F = f;
    @(negedge clk);
  endtask

  task automatic blank(input int n, input logic v, input logic f);
    for (int k = 0; k < n; k++) drive(10'h200, 1'b1, v, f);
  endtask

  // Word i of an active line; every fourth word completes a group whose pair is expected next cycle.
  task automatic drive_active_word(input int i, input bit pattern, input logic f);
    logic [9:0] w;
    int g;
    rec_t r;
    g = i / 4;
    if (pattern) begin
      case (i % 4)
        0: w = 10'h040;
        1: w = 10'(32'h100 + 2 * g);
        2: w = 10'h3C0;
        default: w = 10'(32'h101 + 2 * g);
      endcase
    end else begin
      w = 10'($urandom_range(1019, 4));
    end
    case (i % 4)
      0: g_cb = w;
      1: g_y0 = w;
      2: g_cr = w;
      default: begin
        r = {g_cb, g_y0, g_cr, w, 9'(g), 9'(m_line_y), f, (g == 0), (g == 0) && (m_line_y == 0), 32'(ncyc + 1)};
        exp_q.push_back(r);
      end
    endcase
    drive(w, 1'b0, 1'b0, f);
  endtask

  // One line: blanking, n active words, then preamble or an early H rise, then blanking.
  task automatic send_line(input int n_words, input bit pattern, input bit preamble, input logic f);
    blank(4, 1'b0, f);
    for (int i = 0; i < n_words; i++) drive_active_word(i, pattern, f);
    if (preamble) begin
      if ((n_words % 4 != 0) || (n_words / 4 != 360)) exp_err_q.push_back(ncyc + 1);
      drive(10'h3FF, 1'b0, 1'b0, f);
      drive(10'h000, 1'b0, 1'b0, f);
      drive(10'h000, 1'b0, 1'b0, f);
      drive(10'h274, 1'b0, 1'b0, f);
    end else begin
      exp_err_q.push_back(ncyc + 1);
    end
    if (m_line_y != 511) m_line_y++;
    blank(6, 1'b0, f);
  endtask

  task automatic clear_queues();
    obs_q.delete(); exp_q.delete(); err_q.delete(); exp_err_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; bt_656 = 10'h000; H = 1'b1; V = 1'b0; F = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({pix_valid, line_err, sol, sof, field} !== 5'b0) begin
      fails++; $display("FAIL reset_flags got %b want 00000", {pix_valid, line_err, sol, sof, field});
    end
    checks++;
    if ({pix_cb, pix_y0, pix_cr, pix_y1} !== 40'h0) begin
      fails++; $display("FAIL reset_pair got %h want 0", {pix_cb, pix_y0, pix_cr, pix_y1});
    end
    checks++;
    if ({pix_x, line_y} !== 18'h0) begin
      fails++; $display("FAIL reset_pos got x=%0d y=%0d want 0 0", pix_x, line_y);
    end
    reset = 1'b0;
    blank(4, 1'b0, 1'b0);
    m_line_y = 0;
  endtask

  task automatic test_full_line();
    clear_queues();
    send_line(1440, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != 360) begin
      fails++; $display("FAIL full_line count got %0d want 360", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL full_line pair%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err_q.size() != 0) begin
      fails++; $display("FAIL full_line line_err got %0d pulses want 0", err_q.size());
    end
  endtask

  task automatic test_short_line();
    clear_queues();
    send_line(1000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != 250) begin
      fails++; $display("FAIL short_line count got %0d want 250", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL short_line pair%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if ((err_q.size() != 1) || (err_q[0] != exp_err_q[0])) begin
      fails++; $display("FAIL short_line line_err got %0d pulses (first @%0d) want 1 @%0d",
                        err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, exp_err_q[0]);
    end
  endtask

  task automatic test_misaligned();
    clear_queues();
    send_line(42, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != 10) begin
      fails++; $display("FAIL misaligned count got %0d want 10", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL misaligned pair%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if ((err_q.size() != 1) || (err_q[0] != exp_err_q[0])) begin
      fails++; $display("FAIL misaligned line_err got %0d pulses (first @%0d) want 1 @%0d",
                        err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, exp_err_q[0]);
    end
  endtask

  task automatic test_field_sequence();
    clear_queues();
    blank(4, 1'b1, 1'b0);
    m_line_y = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 20; k++) drive(10'($urandom_range(1019, 4)), 1'b0, 1'b1, 1'b0);
      blank(4, 1'b1, 1'b0);
    end
    send_line(1440, 1'b0, 1'b1, 1'b1);
    send_line(1440, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs_q.size() != 720) begin
      fails++; $display("FAIL field_seq count got %0d want 720", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL field_seq pair%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err_q.size() != 0) begin
      fails++; $display("FAIL field_seq line_err got %0d pulses want 0", err_q.size());
    end
  endtask

  task automatic test_reset_mid_line();
    clear_queues();
    blank(4, 1'b0, 1'b0);
    for (int i = 0; i < 23; i++) drive_active_word(i, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pix_valid, pix_cb, pix_y0, pix_cr, pix_y1, pix_x, line_y, field, sol, sof, line_err} !== '0) begin
      fails++; $display("FAIL reset_mid outputs got x=%0d y=%0d cb=%h not all zero", pix_x, line_y, pix_cb);
    end
    m_line_y = 0;
    for (int k = 0; k < 2; k++) drive(10'($urandom_range(1019, 4)), 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) drive(10'($urandom_range(1019, 4)), 1'b0, 1'b0, 1'b0);
    drive(10'h3FF, 1'b0, 1'b0, 1'b0);
    drive(10'h000, 1'b0, 1'b0, 1'b0);
    drive(10'h000, 1'b0, 1'b0, 1'b0);
    drive(10'h274, 1'b0, 1'b0, 1'b0);
    blank(6, 1'b0, 1'b0);
    send_line(1440, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != 365) begin
      fails++; $display("FAIL reset_mid count got %0d want 365", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL reset_mid pair%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err_q.size() != 0) begin
      fails++; $display("FAIL reset_mid line_err got %0d pulses want 0", err_q.size());
    end
  endtask

  task automatic test_early_h();
    clear_queues();
    send_line(101, 1'b0, 1'b0, 1'b0);
    send_line(1440, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != 385) begin
      fails++; $display("FAIL early_h count got %0d want 385", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL early_h pair%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if ((err_q.size() != 1) || (err_q[0] != exp_err_q[0])) begin
      fails++; $display("FAIL early_h line_err got %0d pulses (first @%0d) want 1 @%0d",
                        err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, exp_err_q[0]);
    end
  endtask

  initial begin
    reset = 1'b1; bt_656 = 10'h000; H = 1'b1; V = 1'b0; F = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_line();
    test_short_line();
    test_misaligned();
    test_field_sequence();
    test_reset_mid_line();
    test_early_h();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/active_video_extractor.md
# active_video_extractor

Consumes the 10-bit BT.656 word stream together with the H/V/F flags produced by `sync_parser`. Extracts the active-video samples of each line and packs every 4:2:2 group (Cb, Y0, Cr, Y1) into one pixel-pair word with a valid strobe. Tags each pair with pair index, active-line index, field and start-of-line/field markers. It is the first stage that downstream scrambling and descrambling logic sees as "pixels" rather than raw bytes.

## Interface
Parameters:
- `ACTIVE_PAIRS`, 360: number of Cb/Y/Cr/Y groups in a complete active line (720 pixels, 1440 words).
- `LINE_W`, 9: width of `line_y`.

Ports:
- `clk`  in  1  video word clock, one BT.656 word per cycle.
- `reset`  in  1  asynchronous, active-high reset.
- `bt_656`  in  10  BT.656 word, aligned with the H/V/F contract below.
- `H`  in  1  from `sync_parser`: 1 = horizontal blanking.
- `V`  in  1  from `sync_parser`: 1 = vertical blanking.
- `F`  in  1  from `sync_parser`: field bit.
- `pix_valid`  out  1  one-cycle strobe; pair outputs are valid.
- `pix_cb`, `pix_y0`, `pix_cr`, `pix_y1`  out  10 each  packed pair.
- `pix_x`  out  9  pair index within the line, 0..ACTIVE_PAIRS-1.
- `line_y`  out  LINE_W  active-line index within the field.
- `field`  out  1  F latched at line start.
- `sol`  out  1  high with the first pair of a line.
- `sof`  out  1  high with the first pair of the first active line of a field.
- `line_err`  out  1  one-cycle pulse at end of a malformed line.

## Operation
- **Input contract.** H/V/F change in the cycle after the XY word of a timing reference is presented on `bt_656`. The first cycle with H=0 therefore carries the first Cb.
- **States:**
  - IDLE: waiting for a line start.
  - ACTIVE: capturing words.
  - DRAIN: preamble seen; waiting for H=1.
- **IDLE → ACTIVE:** on a cycle with H=0, V=0 and the previous registered H=1 (H falling edge). On entry:
  - latch `field` ← F;
  - phase ← 0, pair counter ← 0;
  - the current word is captured as Cb.
- **ACTIVE:**
  - A 2-bit phase selects Cb / Y0 / Cr / Y1; the phase wraps 3 → 0.
  - On the clock edge that captures Y1, all four components load into the output registers, `pix_valid` is set for one cycle, and the pair counter increments.
- **End of line (preamble).** A word of 10'h3FF in ACTIVE ends the line and moves the FSM to DRAIN. The 3FF and the following 000, 000, XY words are never captured.
- **`line_err` conditions.** `line_err` pulses on the cycle after the 3FF if either holds:
  - the 3FF arrived at phase ≠ 0 (the partial group is discarded);
  - the pair count ≠ ACTIVE_PAIRS.
- **End of line (H rises).** H=1 while in ACTIVE ends the line with `line_err` and returns the FSM to IDLE.
- **DRAIN → IDLE:** when H=1.
- **Line counter:**
  - `line_y` clears to 0 on the rising edge of V;
  - `line_y` increments by 1 at every end of line (error or not), saturating at all-ones;
  - `sof` is asserted when `sol` is asserted and `line_y` = 0.
- **No capture during vertical blanking.** An H falling edge while V=1 never leaves IDLE.
- **Mid-line starts.** After reset, or when the first line is entered mid-line, the block waits for the next H falling edge. Partial lines are ignored with no error.
- **Reset values.** All outputs 0, FSM in IDLE, counters 0, registered H_prev = 1.

## Timing
- **Latency:** the Y1 word sampled at edge k gives `pix_valid`=1 during the cycle after edge k, i.e. 1 cycle.
- **Strobe spacing:** `pix_valid` pulses are exactly 4 cycles apart within a line.
- **Output hold:** `pix_*`, `pix_x`, `sol` and `sof` hold their values until the next strobe. `sol` and `sof` are meaningful only while `pix_valid`=1.
- **Error timing:** `line_err` pulses in the cycle after the 3FF, or after the H=1 sample.
- **Simultaneous events:** if a V rising edge and an end of line occur in the same cycle, the clear wins and `line_y` becomes 0.
- **Reset:** asserting `reset` mid-line clears everything asynchronously; no strobe is emitted for the partial group.

## Structure
- **Shared package `video_timing_pkg`:**
  - `PREAMBLE_WORD` = 10'h3FF;
  - `ACTIVE_PAIRS_NTSC` = 360;
  - the FSM state enum {IDLE, ACTIVE, DRAIN}.
- **Sub-module `ycbcr_pair_packer`:** the phase counter, 4-way demux and output registers. It takes a capture-enable and a phase-clear input and returns the pair plus the strobe.
- **Top level:** holds the FSM, H/V edge detection, the pair/line counters and the error logic.

## Test plan
- **Full line:** H falls with V=0, then 1440 words with Cb=0x040, Y0=0x100+2n, Cr=0x3C0, Y1=0x101+2n, then 3FF 000 000 XY and H=1.
  - Expect 360 strobes, `pix_x` 0..359, `sol` only at `pix_x`=0, and no `line_err`.
- **Short line:** 3FF after 1000 words.
  - Expect 250 strobes, then `line_err`=1 for one cycle in the cycle after the 3FF.
- **Misaligned preamble:** 3FF at phase 2 after 10 pairs.
  - Expect 10 strobes, no 11th strobe, and a `line_err` pulse.
- **Field sequence:** V rises, three H-pulses with V=1, then V falls with F=1 and two full lines.
  - Expect no strobes during V=1.
  - Expect `sof`=1 only with the first pair of line 0, `line_y` 0 then 1, and `field`=1.
- **Reset mid-line:** `reset` asserted after 3 words of group 5, then released mid-line.
  - Expect outputs to become 0 immediately.
  - Expect no strobes until the next H falling edge, after which a full line is captured correctly.
- **Early H rise:** H rises in ACTIVE without a preamble.
  - Expect a `line_err` pulse and the FSM back in IDLE.
